// File: rtl/memory_responder.sv
// Word-organised RAM responder for the multicycle RV32I core: byte/half/word
// loads and stores selected by funct3, sub-word stores via read-modify-write.
module memory_responder #(
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        memory_write_en,
  input  logic [31:0] memory_read_address,
  input  logic [31:0] memory_write_address,
  input  logic [31:0] memory_write,
  input  logic [2:0]  memory_funct3,
  output logic        rsp_valid,
  output logic [31:0] memory_read_value,
  output logic        misaligned
);

  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [31:0]       r_mem [DEPTH];
  logic [2:0]        r_funct3;
  logic [31:0]       r_wdata;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_old;
  logic [31:0]       r_read_value;
  logic              r_misaligned;

  logic              w_accept;
  logic [31:0]       w_sel_addr;
  logic              w_error;
  logic [ADDR_W-1:0] w_idx;
  logic [4:0]        w_shamt;
  logic [31:0]       w_word;
  logic [31:0]       w_lane;
  logic [31:0]       w_rd_value;
  logic [31:0]       w_mask;
  logic [31:0]       w_fill;
  logic [31:0]       w_merged;
  logic              w_unused;

  assign w_accept   = req_valid && (r_state == S_IDLE);
  assign w_sel_addr = memory_write_en ? memory_write_address : memory_read_address;
  // Address bits above the array size are ignored, so accesses wrap.
  assign w_unused   = ^w_sel_addr[31:ADDR_W+2];

  always_comb begin
    w_error = 1'b0;
    case (memory_funct3)
      3'b000:  w_error = 1'b0;
      3'b001:  w_error = w_sel_addr[0];
      3'b010:  w_error = |w_sel_addr[1:0];
      3'b100:  w_error = memory_write_en;
      3'b101:  w_error = memory_write_en | w_sel_addr[0];
      default: w_error = 1'b1;
    endcase
  end

  assign w_idx   = r_addr[ADDR_W+1:2];
  assign w_shamt = {r_addr[1:0], 3'b000};
  assign w_word  = r_mem[w_idx];
  assign w_lane  = w_word >> w_shamt;

  // Read data is returned right-aligned; extension is the control unit's job.
  always_comb begin
    w_rd_value = w_word;
    case (r_funct3)
      3'b000, 3'b100: w_rd_value = {24'b0, w_lane[7:0]};
      3'b001, 3'b101: w_rd_value = {16'b0, w_lane[15:0]};
      default:        w_rd_value = w_word;
    endcase
  end

  // Only SB (funct3=000) and SH (funct3=001) reach the merge path.
  assign w_mask   = (r_funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << w_shamt;
  assign w_fill   = r_funct3[0] ? {2{r_wdata[15:0]}} : {4{r_wdata[7:0]}};
  assign w_merged = (r_old & ~w_mask) | (w_fill & w_mask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_error)                      w_next_state = S_RESP;
          else if (!memory_write_en)        w_next_state = S_RD;
          else if (memory_funct3 == 3'b010) w_next_state = S_WR;
          else                              w_next_state = S_RMW_RD;
        end
      end
      S_RD:     w_next_state = S_RESP;
      S_WR:     w_next_state = S_RESP;
      S_RMW_RD: w_next_state = S_RMW_WR;
      S_RMW_WR: w_next_state = S_RESP;
      S_RESP:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready         = (r_state == S_IDLE);
    rsp_valid         = (r_state == S_RESP);
    memory_read_value = r_read_value;
    misaligned        = r_misaligned;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_funct3     <= 3'b000;
      r_wdata      <= 32'h0;
      r_addr       <= '0;
      r_old        <= 32'h0;
      r_read_value <= 32'h0;
      r_misaligned <= 1'b0;
    end else begin
      if (w_accept) begin
        r_funct3     <= memory_funct3;
        r_wdata      <= memory_write;
        r_addr       <= w_sel_addr[ADDR_W+1:0];
        r_misaligned <= w_error;
        if (w_error) r_read_value <= 32'h0;
      end
      if (r_state == S_RD)     r_read_value <= w_rd_value;
      if (r_state == S_RMW_RD) r_old        <= w_word;
    end
  end

  // NOTE: the array has no reset; clearing it would prevent RAM inference,
  // and a reset mid-store is safe because the state register drops to IDLE.
  always_ff @(posedge clk) begin
    if (r_state == S_WR)          r_mem[w_idx] <= r_wdata;
    else if (r_state == S_RMW_WR) r_mem[w_idx] <= w_merged;
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: word and sub-word access, error
// responses, address wrap, handshake timing and reset during a store.
module tb_memory_responder;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        memory_write_en;
  logic [31:0] memory_read_address;
  logic [31:0] memory_write_address;
  logic [31:0] memory_write;
  logic [2:0]  memory_funct3;
  logic        rsp_valid;
  logic [31:0] memory_read_value;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  memory_responder #(.DEPTH(1024)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .memory_write_en      (memory_write_en),
    .memory_read_address  (memory_read_address),
    .memory_write_address (memory_write_address),
    .memory_write         (memory_write),
    .memory_funct3        (memory_funct3),
    .rsp_valid            (rsp_valid),
    .memory_read_value    (memory_read_value),
    .misaligned           (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Issues one request, scrambles inputs after acceptance, and reports the
  // response latency in cycles (-1 on timeout) plus the response contents.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, output int lat, output logic [31:0] val,
                       output logic mis, output logic rsp_after);
    @(negedge clk);
    req_valid            = 1'b1;
    memory_write_en      = we;
    memory_read_address  = we ? 32'h0000_0FFC : addr;
    memory_write_address = we ? addr : 32'h0000_0FFC;
    memory_write         = wdata;
    memory_funct3        = f3;
    @(posedge clk);
    #1;
    req_valid            = 1'b0;
    memory_write_en      = ~we;
    memory_read_address  = 32'h0;
    memory_write_address = 32'h0;
    memory_write         = 32'h5A5A_5A5A;
    memory_funct3        = 3'b111;
    lat = -1;
    val = 32'h0;
    mis = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        val = memory_read_value;
        mis = misaligned;
        break;
      end
    end
    @(negedge clk);
    rsp_after = rsp_valid;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = 1'b0;
    memory_write_en = 1'b0;
    memory_read_address = 32'h0;
    memory_write_address = 32'h0;
    memory_write = 32'h0;
    memory_funct3 = 3'b000;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++;
    if (memory_read_value !== 32'h0) begin errors++; $display("FAIL reset_read_value got %h exp 00000000", memory_read_value); end
    checks++;
    if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned got %b exp 0", misaligned); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_word();
    int lat; logic [31:0] val; logic mis, after;
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, lat, val, mis, after);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL sw_latency got %0d exp 2", lat); end
    checks++;
    if (val !== 32'h0) begin errors++; $display("FAIL sw_value_held got %h exp 00000000", val); end
    checks++;
    if (mis !== 1'b0) begin errors++; $display("FAIL sw_misaligned got %b exp 0", mis); end
    checks++;
    if (after !== 1'b0) begin errors++; $display("FAIL sw_single_strobe got %b exp 0", after); end
    issue(1'b0, 32'h10, 32'h0, 3'b010, lat, val, mis, after);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL lw_latency got %0d exp 2", lat); end
    checks++;
    if (val !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_value got %h exp deadbeef", val); end
    checks++;
    if (mis !== 1'b0) begin errors++; $display("FAIL lw_misaligned got %b exp 0", mis); end
  endtask

  task automatic test_subword();
    int lat; logic [31:0] val; logic mis, after;
    issue(1'b1, 32'h11, 32'hFFFF_FFA5, 3'b000, lat, val, mis, after);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL sb_latency got %0d exp 3", lat); end
    checks++;
    if (val !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sb_value_held got %h exp deadbeef", val); end
    issue(1'b0, 32'h10, 32'h0, 3'b010, lat, val, mis, after);
    checks++;
    if (val !== 32'hDEAD_A5EF) begin errors++; $display("FAIL sb_merge got %h exp deada5ef", val); end
    issue(1'b0, 32'h11, 32'h0, 3'b000, lat, val, mis, after);
    checks++;
    if (val !== 32'h0000_00A5) begin errors++; $display("FAIL lb_unextended got %h exp 000000a5", val); end
    issue(1'b1, 32'h12, 32'h0000_1234, 3'b001, lat, val, mis, after);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL sh_latency got %0d exp 3", lat); end
    issue(1'b0, 32'h12, 32'h0, 3'b101, lat, val, mis, after);
    checks++;
    if (val !== 32'h0000_1234) begin errors++; $display("FAIL lhu_value got %h exp 00001234", val); end
    issue(1'b0, 32'h10, 32'h0, 3'b010, lat, val, mis, after);
    checks++;
    if (val !== 32'h1234_A5EF) begin errors++; $display("FAIL sh_merge got %h exp 1234a5ef", val); end
    issue(1'b0, 32'h10, 32'h0, 3'b001, lat, val, mis, after);
    checks++;
    if (val !== 32'h0000_A5EF) begin errors++; $display("FAIL lh_unextended got %h exp 0000a5ef", val); end
    issue(1'b0, 32'h13, 32'h0, 3'b100, lat, val, mis, after);
    checks++;
    if (val !== 32'h0000_0012) begin errors++; $display("FAIL lbu_lane3 got %h exp 00000012", val); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL lbu_latency got %0d exp 2", lat); end
  endtask

  task automatic test_errors();
    logic        t_we   [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] t_addr [7] = '{32'h13, 32'h11, 32'h22, 32'h10, 32'h10, 32'h11, 32'h10};
    logic [2:0]  t_f3   [7] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100, 3'b001, 3'b110};
    int lat; logic [31:0] val; logic mis, after;
    issue(1'b1, 32'h20, 32'hCAFE_F00D, 3'b010, lat, val, mis, after);
    for (int i = 0; i < 7; i++) begin
      issue(t_we[i], t_addr[i], 32'hBAD0_BAD0, t_f3[i], lat, val, mis, after);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL err%0d_latency got %0d exp 1", i, lat); end
      checks++;
      if (mis !== 1'b1) begin errors++; $display("FAIL err%0d_misaligned got %b exp 1", i, mis); end
      checks++;
      if (val !== 32'h0) begin errors++; $display("FAIL err%0d_value got %h exp 00000000", i, val); end
    end
    issue(1'b0, 32'h20, 32'h0, 3'b010, lat, val, mis, after);
    checks++;
    if (val !== 32'hCAFE_F00D) begin errors++; $display("FAIL err_word20_kept got %h exp cafef00d", val); end
    checks++;
    if (mis !== 1'b0) begin errors++; $display("FAIL err_flag_cleared got %b exp 0", mis); end
    issue(1'b0, 32'h10, 32'h0, 3'b010, lat, val, mis, after);
    checks++;
    if (val !== 32'h1234_A5EF) begin errors++; $display("FAIL err_word10_kept got %h exp 1234a5ef", val); end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] val; logic mis, after;
    issue(1'b1, 32'h1000, 32'h1111_1111, 3'b010, lat, val, mis, after);
    issue(1'b0, 32'h0, 32'h0, 3'b010, lat, val, mis, after);
    checks++;
    if (val !== 32'h1111_1111) begin errors++; $display("FAIL wrap_word0 got %h exp 11111111", val); end
    issue(1'b0, 32'hFFFF_F010, 32'h0, 3'b010, lat, val, mis, after);
    checks++;
    if (val !== 32'h1234_A5EF) begin errors++; $display("FAIL wrap_high_bits got %h exp 1234a5ef", val); end
  endtask

  task automatic test_handshake();
    @(negedge clk);
    req_valid = 1'b1;
    memory_write_en = 1'b0;
    memory_read_address = 32'h10;
    memory_write_address = 32'h0;
    memory_funct3 = 3'b010;
    @(posedge clk);
    #1;
    memory_read_address = 32'h0;
    memory_funct3 = 3'b000;
    memory_write_en = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL hs_rd_cycle got ready=%b rsp=%b exp ready=0 rsp=0", req_ready, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL hs_resp_cycle got ready=%b rsp=%b exp ready=0 rsp=1", req_ready, rsp_valid);
    end
    checks++;
    if (memory_read_value !== 32'h1234_A5EF) begin
      errors++; $display("FAIL hs_inputs_ignored got %h exp 1234a5ef", memory_read_value);
    end
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL hs_idle_cycle got ready=%b rsp=%b exp ready=1 rsp=0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_store();
    int lat; int seen; logic [31:0] val; logic mis, after;
    @(negedge clk);
    req_valid = 1'b1;
    memory_write_en = 1'b1;
    memory_write_address = 32'h10;
    memory_read_address = 32'h0;
    memory_write = 32'h0000_0077;
    memory_funct3 = 3'b000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_async_idle got ready=%b exp 1", req_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_no_response got %0d strobes exp 0", seen); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", req_ready); end
    issue(1'b0, 32'h10, 32'h0, 3'b010, lat, val, mis, after);
    checks++;
    if (val !== 32'h1234_A5EF) begin errors++; $display("FAIL rst_word_unchanged got %h exp 1234a5ef", val); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_wrap();
    test_handshake();
    test_reset_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
